deslocador_seq: RTL and testbench



---
 rtl/mips_pkg.sv | 24 ++
 rtl/deslocador_passo.sv | 41 ++++
 rtl/deslocador_seq.sv | 91 +++++++++
 tb/tb_deslocador_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the multi-cycle datapath: shift modes and shifter FSM states.
package mips_pkg;

    // Shift operation selected by the 2-bit modo field
    typedef enum logic [1:0] {
        MODO_SLL = 2'b00,
        MODO_SRL = 2'b01,
        MODO_SRA = 2'b10,
        MODO_ROL = 2'b11
    } modo_t;

    // Sequential shifter control states
    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        DESLOCA = 2'b01,
        FIM     = 2'b10
    } estado_t;

    // Bits to shift this step: the remaining amount, capped at the per-cycle step
    function automatic int passo_k(input int restante, input int passo);
        return (restante > passo) ? passo : restante;
    endfunction

endpackage

// File: rtl/deslocador_passo.sv
// Single-step combinational shifter: shifts acc by k (0..STEP) according to modo.
// Rotate-left for modo=11 is only built when DESLOCADOR_ROTATE_EN is defined;
// otherwise modo=11 falls through to SLL.
module deslocador_passo
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int K_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [K_W-1:0]   k,
    input  modo_t            modo,
    output logic [WIDTH-1:0] acc_prox
);

    logic [K_W-1:0] k_lim;

    // Clamp the step amount so a bad k can never exceed the step size
    always_comb begin
        k_lim = k;
        if (int'(k) > STEP) begin
            k_lim = K_W'(STEP);
        end
    end

    // Apply one shift step; SRA replicates the current sign bit of acc
    always_comb begin
        acc_prox = acc << k_lim;
        case (modo)
            MODO_SRL: acc_prox = acc >> k_lim;
            MODO_SRA: acc_prox = $signed(acc) >>> k_lim;
`ifdef DESLOCADOR_ROTATE_EN
            // k_lim=0 shifts right by WIDTH, which yields zero, leaving acc intact
            MODO_ROL: acc_prox = (acc << k_lim) | (acc >> (WIDTH - int'(k_lim)));
`endif
            default:  acc_prox = acc << k_lim;
        endcase
    end

endmodule

// File: rtl/deslocador_seq.sv
// Multi-cycle shifter with start/done handshake; shifts at most STEP bits per cycle.
// Optional rotate-left mode (modo=11) enabled by macro DESLOCADOR_ROTATE_EN.
module deslocador_seq
    import mips_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic [WIDTH-1:0]   entrada,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         modo,
    output logic [WIDTH-1:0]   saida,
    output logic               ocupado,
    output logic               pronto
);

    localparam int K_W = $clog2(STEP + 1);

    estado_t            estado;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] rem;
    modo_t              modo_r;
    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   acc_prox;
    logic               ultimo;

    // Step size for this cycle and last-step detection
    always_comb begin
        k      = K_W'(passo_k(int'(rem), STEP));
        ultimo = (int'(rem) <= STEP);
    end

    deslocador_passo #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .K_W   (K_W)
    ) u_passo (
        .acc      (acc),
        .k        (k),
        .modo     (modo_r),
        .acc_prox (acc_prox)
    );

    // Control FSM with registered outputs; saida only updates on the last step
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= OCIOSO;
            acc     <= '0;
            rem     <= '0;
            modo_r  <= MODO_SLL;
            saida   <= '0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        acc     <= entrada;
                        rem     <= shamt;
                        modo_r  <= modo_t'(modo);
                        ocupado <= 1'b1;
                        estado  <= DESLOCA;
                    end
                end
                DESLOCA: begin
                    acc <= acc_prox;
                    rem <= rem - SHAMT_W'(k);
                    if (ultimo) begin
                        saida  <= acc_prox;
                        estado <= FIM;
                    end
                end
                FIM: begin
                    pronto  <= 1'b1;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: begin
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deslocador_seq.sv
// Scoreboard bench for deslocador_seq (WIDTH=32, STEP=4).
module tb_deslocador_seq;

    logic        clock;
    logic        reset;
    logic        inicio;
    logic [31:0] entrada;
    logic [4:0]  shamt;
    logic [1:0]  modo;
    logic [31:0] saida;
    logic        ocupado;
    logic        pronto;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int run      = 0;
    int last_run = 0;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        int          ocup;
        string       name;
    } exp_t;

    exp_t q[$];

    deslocador_seq #(
        .WIDTH (32),
        .STEP  (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .inicio  (inicio),
        .entrada (entrada),
        .shamt   (shamt),
        .modo    (modo),
        .saida   (saida),
        .ocupado (ocupado),
        .pronto  (pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // Whole-word reference: the stepwise shift composes into one shift of shamt bits
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] m);
        logic signed [31:0] sd;
        sd = d;
        case (m)
            2'b01: return d >> s;
            2'b10: return sd >>> s;
`ifdef DESLOCADOR_ROTATE_EN
            2'b11: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
`endif
            default: return d << s;
        endcase
    endfunction

    function automatic int n_cycles(input int s);
        return (s == 0) ? 1 : (s + 3) / 4;
    endfunction

    // Monitor: pops one expectation per pronto pulse
    always @(negedge clock) begin
        exp_t e;
        if (ocupado) run++;
        else if (run > 0) begin
            last_run = run;
            run = 0;
        end
        if (pronto) begin
            if (q.size() == 0) chk("pronto_spurious", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk({"saida_", e.name}, saida, e.val);
                chk({"pronto_cycle_", e.name}, cyc, e.cyc);
                chk({"ocupado_cycles_", e.name}, last_run, e.ocup);
            end
        end
    end

    // Called at posedge+1 with DUT idle; acceptance happens at the next edge
    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                         input logic [31:0] expv, input string nm, input bit push);
        int a;
        int n;
        n = n_cycles(int'(s));
        entrada = d;
        shamt   = s;
        modo    = m;
        inicio  = 1'b1;
        a = cyc + 1;
        if (push) q.push_back('{val: expv, cyc: a + n + 1, ocup: n + 1, name: nm});
        @(posedge clock);
        #1;
        inicio  = 1'b0;
        entrada = $urandom;
        shamt   = 5'($urandom);
        modo    = 2'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        if (q.size() != 0) begin
            chk("timeout_pending", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        int a1;
        int a2;
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  m;
        logic [31:0] rol_exp;

        reset   = 1'b0;
        inicio  = 1'b0;
        entrada = '0;
        shamt   = '0;
        modo    = '0;
        #12;
        chk("reset_saida", saida, 32'd0);
        chk("reset_ocupado", {31'd0, ocupado}, 32'd0);
        chk("reset_pronto", {31'd0, pronto}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed cases
        issue(32'h0000_0001, 5'd10, 2'b00, 32'h0000_0400, "sll10", 1'b1);
        wait_done();
        issue(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, "sra31", 1'b1);
        wait_done();
        issue(32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, "srl31", 1'b1);
        wait_done();
        issue(32'hDEAD_BEEF, 5'd0, 2'b01, 32'hDEAD_BEEF, "shamt0", 1'b1);
        wait_done();
        issue(32'h1234_5678, 5'd4, 2'b00, 32'h2345_6780, "sll4_exact", 1'b1);
        wait_done();
`ifdef DESLOCADOR_ROTATE_EN
        rol_exp = 32'h0000_0018;
`else
        rol_exp = 32'h0000_0010;
`endif
        issue(32'h8000_0001, 5'd4, 2'b11, rol_exp, "modo11", 1'b1);
        wait_done();

        // Busy protection: a pulse during DESLOCA must be ignored
        issue(32'h0000_0001, 5'd10, 2'b00, 32'h0000_0400, "busy_pulse", 1'b1);
        @(posedge clock);
        #1;
        entrada = 32'hFFFF_FFFF;
        shamt   = 5'd3;
        modo    = 2'b01;
        inicio  = 1'b1;
        @(posedge clock);
        #1;
        inicio  = 1'b0;
        wait_done();
        repeat (4) @(posedge clock);
        #1;

        // inicio held through FIM: second op accepted N1+2 edges after the first
        entrada = 32'hF000_0000;
        shamt   = 5'd8;
        modo    = 2'b01;
        inicio  = 1'b1;
        a1 = cyc + 1;
        q.push_back('{val: 32'h00F0_0000, cyc: a1 + 3, ocup: 3, name: "held_a"});
        a2 = a1 + 4;
        q.push_back('{val: 32'hFFFF_FFFF, cyc: a2 + 9, ocup: 9, name: "held_b"});
        @(posedge clock);
        #1;
        entrada = 32'h8000_0000;
        shamt   = 5'd31;
        modo    = 2'b10;
        for (int i = 0; i < 20 && cyc < a2; i++) begin
            @(posedge clock);
            #1;
        end
        inicio = 1'b0;
        wait_done();

        // Asynchronous reset in the middle of DESLOCA
        issue(32'h0000_0001, 5'd20, 2'b00, 32'h0, "aborted", 1'b0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("midreset_saida", saida, 32'd0);
        chk("midreset_ocupado", {31'd0, ocupado}, 32'd0);
        chk("midreset_pronto", {31'd0, pronto}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        chk("post_reset_saida", saida, 32'd0);

        // Randomised operations against the reference model
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            m = 2'($urandom_range(0, 3));
            issue(d, s, m, ref_shift(d, int'(s), m), "rand", 1'b1);
            wait_done();
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

        repeat (5) @(posedge clock);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
